// File: rtl/mux_table_arbiter.sv
// Round-robin arbiter that shares one 2-input logic-table evaluator among NREQ requesters.
// Each winner's operands are sampled at grant, evaluated once, and the result is held until acknowledged.
module mux_table_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] d_in,
    input  logic [2*NREQ-1:0] f_in,
    output logic [NREQ-1:0]   gnt,
    output logic              y_out,
    output logic              y_valid,
    output logic [IDW-1:0]    y_id,
    input  logic              y_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    id_q;
    logic [1:0]        op_q;
    logic [1:0]        func_q;

    logic [2*NREQ-1:0] req_dbl;
    logic              req_found;
    logic [IDW-1:0]    win_idx;
    int                win_sum;
    logic [2*NREQ-1:0] d_shift;
    logic [2*NREQ-1:0] f_shift;

    logic              xor_sel;
    logic              nornand_sel;
    logic              y_eval;

    // Evaluator: mux2_1 picks XOR/XNOR, mux2_2 picks NOR/NAND, final mux2 on func[1].
    assign xor_sel     = func_q[0] ? ~(op_q[1] ^ op_q[0]) : (op_q[1] ^ op_q[0]);
    assign nornand_sel = func_q[0] ? ~(op_q[1] & op_q[0]) : ~(op_q[1] | op_q[0]);
    assign y_eval      = func_q[1] ? nornand_sel : xor_sel;

    assign busy = (state != IDLE);

    // Rotating the doubled request vector puts ptr at bit 0, so the scan below is a plain priority search.
    assign req_dbl = {req, req} >> ptr;
    assign d_shift = d_in >> {win_idx, 1'b0};
    assign f_shift = f_in >> {win_idx, 1'b0};

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        req_found = 1'b0;
        win_idx   = '0;
        win_sum   = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!req_found && req_dbl[k]) begin
                req_found = 1'b1;
                win_sum   = int'(ptr) + k;
                if (win_sum >= NREQ) win_sum = win_sum - NREQ;
                win_idx   = IDW'(win_sum);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_found) state_nxt = EVAL;
            EVAL:    state_nxt = RESULT;
            RESULT:  if (y_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the captured operand/id registers are reset too, so nothing stale survives an aborted transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            id_q    <= '0;
            op_q    <= '0;
            func_q  <= '0;
            gnt     <= '0;
            y_out   <= 1'b0;
            y_valid <= 1'b0;
            y_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_found) begin
                        op_q   <= d_shift[1:0];
                        func_q <= f_shift[1:0];
                        id_q   <= win_idx;
                        gnt    <= NREQ'(1) << win_idx;
                    end
                end
                EVAL: begin
                    gnt     <= '0;
                    y_out   <= y_eval;
                    y_id    <= id_q;
                    y_valid <= 1'b1;
                end
                RESULT: begin
                    if (y_ack) begin
                        y_valid <= 1'b0;
                        ptr     <= (y_id == IDW'(NREQ - 1)) ? '0 : y_id + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mux_table_arbiter.md
Name: mux_table_arbiter

Overview:
- Shares one 2-input logic-table evaluator among NREQ requesters.
- Each requester submits a 2-bit operand pair and a 2-bit function code.
- The block arbitrates round-robin, captures the winner's operands, evaluates once, and holds the result until the consumer acknowledges.
- It sits between the requesters and the single evaluator, which is built from mux2_1 (XOR/XNOR), mux2_2 (NOR/NAND) and a mux2 on f[1].

Parameters:
- NREQ, 4, number of requesters (legal 2..8).
- IDW, 3, width of y_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request; held until that requester's gnt.
- d_in  in  2*NREQ  operand pairs; requester i uses d_in[2i+1:2i].
- f_in  in  2*NREQ  function codes; requester i uses f_in[2i+1:2i]. 00 XOR, 01 XNOR, 10 NOR, 11 NAND.
- gnt  out  NREQ  registered one-hot grant; one-cycle pulse.
- y_out  out  1  evaluated result.
- y_valid  out  1  result valid; held until accepted.
- y_id  out  IDW  index of the requester that owns y_out.
- y_ack  in  1  consumer accepts the result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, ptr=0, gnt=0, y_out=0, y_valid=0, y_id=0, busy=0. Internal operand, function and id registers are 0.
- FSM states: IDLE, EVAL, RESULT.

IDLE:
- If req==0: stay in IDLE.
- Otherwise the winner is the first set bit searching ptr, ptr+1, ... wrapping modulo NREQ.
- On the same edge: capture d_in/f_in slices and index of the winner; gnt <= onehot(winner); state <= EVAL.

EVAL (exactly one cycle):
- gnt is high for this cycle only; it returns to 0 at the next edge.
- y_out <= table(op, func):
  - XOR: op[1]^op[0]
  - XNOR: ~(op[1]^op[0])
  - NOR: ~(op[1]|op[0])
  - NAND: ~(op[1]&op[0])
- y_id <= captured index; y_valid <= 1; state <= RESULT.

RESULT:
- y_out, y_id and y_valid are held stable.
- When y_ack=1 at an edge: y_valid <= 0; ptr <= (y_id+1) mod NREQ; state <= IDLE.

Timing and throughput:
- req seen at edge k gives gnt high in cycle k+1 and y_valid high from cycle k+2.
- Minimum transaction is 3 cycles when y_ack is tied high.
- No pipelining: the next arbitration happens only after returning to IDLE.

Boundary conditions:
- Operands and function are sampled only at the grant edge. Later changes to d_in/f_in do not affect y_out.
- A requester that keeps req high after its gnt is treated as a new request. It gets lower priority, because ptr has moved past it.
- A req dropped before it is granted is simply not considered; no error is flagged.
- y_ack outside RESULT is ignored.
- y_ack already high when y_valid rises is accepted at the following edge, so y_valid is high for at least 1 cycle.
- Single requester, always requesting: it is served every 3 cycles (ptr wraps back to it).
- ptr wrap: if y_id==NREQ-1, ptr becomes 0.
- Reset asserted mid-transaction: the in-flight result is discarded. All outputs go to reset values immediately (asynchronously); no gnt or y_valid glitch follows reset release.
- Unused req bits (NREQ < 2^IDW): not applicable; y_id never exceeds NREQ-1.

Test Plan:
1. Reset, then req=4'b0001, d_in[1:0]=2'b10, f_in[1:0]=2'b00, y_ack=1.
   -> gnt=4'b0001 for one cycle; y_valid=1 next cycle with y_out=1, y_id=0; busy low again after ack.
2. Function sweep on requester 2 with op=2'b11, f=00/01/10/11 in sequence.
   -> y_out=0,1,0,0. Repeat with op=2'b00 -> y_out=0,1,1,1.
3. From reset, req=4'b1010 held continuously, y_ack=1.
   -> grant order id1, id3, id1, id3; each gnt one cycle wide, spaced 3 cycles apart.
4. From reset, req=4'b1111 held continuously, y_ack=1.
   -> grant order 0,1,2,3,0; ptr wraps from 3 to 0.
5. Back-pressure: y_ack=0 for 5 cycles after y_valid rises; change d_in during the wait.
   -> y_valid, y_out and y_id stay stable; no new gnt. Ack on cycle 6 -> y_valid=0 and IDLE next cycle.
6. Assert rst_n=0 during EVAL, then release.
   -> gnt, y_valid and busy go to 0 immediately; ptr=0. With req=4'b0100 after release -> gnt=4'b0100.
